// File: rtl/lfsr.sv
// Fibonacci-style XNOR LFSR with seed load and seed-match flag.
// Advances by left shift with feedback entering at the LSB; all-ones is the lockup state.
module lfsr #(
    parameter int NUM_BITS = 128
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Enable,
    input  logic                i_Seed_DV,
    input  logic [NUM_BITS-1:0] i_Seed_Data,
    output logic [NUM_BITS-1:0] o_LFSR_Data,
    output logic                o_LFSR_Done
);

    logic [NUM_BITS-1:0] r_LFSR;
    logic                w_XNOR;

    // Tap k (1-indexed) selects r_LFSR[k-1]; only the matching branch is elaborated.
    generate
        case (NUM_BITS)
            3:   begin : g_taps assign w_XNOR = ~^{r_LFSR[2], r_LFSR[1]}; end
            4:   begin : g_taps assign w_XNOR = ~^{r_LFSR[3], r_LFSR[2]}; end
            5:   begin : g_taps assign w_XNOR = ~^{r_LFSR[4], r_LFSR[2]}; end
            6:   begin : g_taps assign w_XNOR = ~^{r_LFSR[5], r_LFSR[4]}; end
            7:   begin : g_taps assign w_XNOR = ~^{r_LFSR[6], r_LFSR[5]}; end
            8:   begin : g_taps assign w_XNOR = ~^{r_LFSR[7], r_LFSR[5], r_LFSR[4], r_LFSR[3]}; end
            9:   begin : g_taps assign w_XNOR = ~^{r_LFSR[8], r_LFSR[4]}; end
            10:  begin : g_taps assign w_XNOR = ~^{r_LFSR[9], r_LFSR[6]}; end
            11:  begin : g_taps assign w_XNOR = ~^{r_LFSR[10], r_LFSR[8]}; end
            12:  begin : g_taps assign w_XNOR = ~^{r_LFSR[11], r_LFSR[5], r_LFSR[3], r_LFSR[0]}; end
            13:  begin : g_taps assign w_XNOR = ~^{r_LFSR[12], r_LFSR[3], r_LFSR[2], r_LFSR[0]}; end
            14:  begin : g_taps assign w_XNOR = ~^{r_LFSR[13], r_LFSR[4], r_LFSR[2], r_LFSR[0]}; end
            15:  begin : g_taps assign w_XNOR = ~^{r_LFSR[14], r_LFSR[13]}; end
            16:  begin : g_taps assign w_XNOR = ~^{r_LFSR[15], r_LFSR[14], r_LFSR[12], r_LFSR[3]}; end
            17:  begin : g_taps assign w_XNOR = ~^{r_LFSR[16], r_LFSR[13]}; end
            18:  begin : g_taps assign w_XNOR = ~^{r_LFSR[17], r_LFSR[10]}; end
            19:  begin : g_taps assign w_XNOR = ~^{r_LFSR[18], r_LFSR[5], r_LFSR[1], r_LFSR[0]}; end
            20:  begin : g_taps assign w_XNOR = ~^{r_LFSR[19], r_LFSR[16]}; end
            21:  begin : g_taps assign w_XNOR = ~^{r_LFSR[20], r_LFSR[18]}; end
            22:  begin : g_taps assign w_XNOR = ~^{r_LFSR[21], r_LFSR[20]}; end
            23:  begin : g_taps assign w_XNOR = ~^{r_LFSR[22], r_LFSR[17]}; end
            24:  begin : g_taps assign w_XNOR = ~^{r_LFSR[23], r_LFSR[22], r_LFSR[21], r_LFSR[16]}; end
            25:  begin : g_taps assign w_XNOR = ~^{r_LFSR[24], r_LFSR[21]}; end
            26:  begin : g_taps assign w_XNOR = ~^{r_LFSR[25], r_LFSR[5], r_LFSR[1], r_LFSR[0]}; end
            27:  begin : g_taps assign w_XNOR = ~^{r_LFSR[26], r_LFSR[4], r_LFSR[1], r_LFSR[0]}; end
            28:  begin : g_taps assign w_XNOR = ~^{r_LFSR[27], r_LFSR[24]}; end
            29:  begin : g_taps assign w_XNOR = ~^{r_LFSR[28], r_LFSR[26]}; end
            30:  begin : g_taps assign w_XNOR = ~^{r_LFSR[29], r_LFSR[5], r_LFSR[3], r_LFSR[0]}; end
            31:  begin : g_taps assign w_XNOR = ~^{r_LFSR[30], r_LFSR[27]}; end
            32:  begin : g_taps assign w_XNOR = ~^{r_LFSR[31], r_LFSR[21], r_LFSR[1], r_LFSR[0]}; end
            64:  begin : g_taps assign w_XNOR = ~^{r_LFSR[63], r_LFSR[62], r_LFSR[60], r_LFSR[59]}; end
            128: begin : g_taps assign w_XNOR = ~^{r_LFSR[127], r_LFSR[125], r_LFSR[100], r_LFSR[98]}; end
            default: begin : g_taps
                $error("lfsr: unsupported NUM_BITS %0d", NUM_BITS);
                assign w_XNOR = 1'b0;
            end
        endcase
    endgenerate

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_LFSR <= '0;
        end else if (i_Enable && i_Seed_DV) begin
            r_LFSR <= i_Seed_Data;
        end else if (i_Enable) begin
            r_LFSR <= {r_LFSR[NUM_BITS-2:0], w_XNOR};
        end
    end

    assign o_LFSR_Data = r_LFSR;
    assign o_LFSR_Done = (r_LFSR == i_Seed_Data);

endmodule

// File: tb/tb_lfsr.sv
// Directed self-checking bench for lfsr at widths 3, 4 and 128 sharing one control stream.
module tb_lfsr;

    logic         clk = 1'b0;
    logic         rst, en, dv;
    logic [2:0]   s3;
    logic [3:0]   s4;
    logic [127:0] s128;
    logic [2:0]   o3;
    logic [3:0]   o4;
    logic [127:0] o128;
    logic         d3, d4, d128;

    int n_assert = 0;
    int n_fail   = 0;

    // Hand-derived XNOR sequences starting from zero (index = number of advances)
    logic [2:0] seq3 [7]  = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100};
    logic [3:0] seq4 [16] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                              4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};

    always #5 clk = ~clk;

    lfsr #(.NUM_BITS(3)) u_l3 (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(dv),
        .i_Seed_Data(s3), .o_LFSR_Data(o3), .o_LFSR_Done(d3)
    );

    lfsr #(.NUM_BITS(4)) u_l4 (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(dv),
        .i_Seed_Data(s4), .o_LFSR_Data(o4), .o_LFSR_Done(d4)
    );

    lfsr #(.NUM_BITS(128)) u_l128 (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Seed_DV(dv),
        .i_Seed_Data(s128), .o_LFSR_Data(o128), .o_LFSR_Done(d128)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [127:0] exp128;

        // Reset wins over a simultaneous enable+load
        rst = 1'b1; en = 1'b1; dv = 1'b1;
        s3 = 3'b000; s4 = 4'h0; s128 = {4{32'hDEADBEEF}};
        tick();
        chk("rst_o3", 128'(o3), 128'(3'b000));
        chk("rst_o4", 128'(o4), 128'(4'h0));
        chk("rst_o128", o128, '0);
        chk("rst_d3", 128'(d3), 128'(1'b1));
        chk("rst_d128", 128'(d128), 128'(1'b0));

        // Free run from zero: 3-bit period 7, 4-bit period 15, 128-bit fills with ones
        rst = 1'b0; dv = 1'b0; s128 = '0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp128 = (128'd1 << k) - 128'd1;
            chk($sformatf("run_o3_%0d", k), 128'(o3), 128'(seq3[k % 7]));
            chk($sformatf("run_o4_%0d", k), 128'(o4), 128'(seq4[k]));
            chk($sformatf("run_d4_%0d", k), 128'(d4), 128'(k == 15));
            chk($sformatf("run_o128_%0d", k), o128, exp128);
            if (k == 7) chk("period_d3", 128'(d3), 128'(1'b1));
        end

        // Seed valid without enable is ignored; changing seeds touches only Done
        en = 1'b0; dv = 1'b1;
        s3 = 3'b111; s4 = 4'hA; s128 = {4{32'hCAFEFEED}};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("hold_o3_%0d", k), 128'(o3), 128'(3'b001));
            chk($sformatf("hold_o4_%0d", k), 128'(o4), 128'(4'h0));
            chk($sformatf("hold_o128_%0d", k), o128, 128'h7FFF);
        end
        chk("hold_d4", 128'(d4), 128'(1'b0));

        // Load, then advance: 3-bit all-ones locks up
        en = 1'b1; dv = 1'b1;
        tick();
        chk("load_o3", 128'(o3), 128'(3'b111));
        chk("load_o4", 128'(o4), 128'(4'hA));
        chk("load_o128", o128, {4{32'hCAFEFEED}});
        chk("load_d128", 128'(d128), 128'(1'b1));
        chk("load_d3", 128'(d3), 128'(1'b1));
        dv = 1'b0;
        tick();
        chk("lock1_o3", 128'(o3), 128'(3'b111));
        chk("adv_o4", 128'(o4), 128'(4'h4));
        chk("adv_d128", 128'(d128), 128'(1'b0));
        tick();
        chk("lock2_o3", 128'(o3), 128'(3'b111));

        // 128-bit single advance from DEADBEEF x4: feedback bit is 1
        dv = 1'b1; s128 = {4{32'hDEADBEEF}};
        tick();
        chk("deadbeef_load", o128, {4{32'hDEADBEEF}});
        dv = 1'b0;
        tick();
        chk("deadbeef_adv", o128, {4{32'hBD5B7DDF}});
        chk("deadbeef_d_low", 128'(d128), 128'(1'b0));
        s128 = {4{32'hBD5B7DDF}};
        #1;
        chk("comb_done", 128'(d128), 128'(1'b1));

        // Mid-sequence reset, then advancing resumes from zero
        rst = 1'b1;
        tick();
        chk("midrst_o3", 128'(o3), 128'(3'b000));
        chk("midrst_o128", o128, '0);
        rst = 1'b0;
        tick();
        chk("resume_o3", 128'(o3), 128'(3'b001));
        chk("resume_o4", 128'(o4), 128'(4'h1));
        chk("resume_o128", o128, 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr.md
LFSR -- requirements
Module: lfsr

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Parameter NUM_BITS SHALL default to 128 and sets the register width.
REQ-003 Port i_Clk SHALL be an input, 1 bit wide, and is the clock; all state updates on its rising edge.
REQ-004 Port i_Rst SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-005 Port i_Enable SHALL be an input, 1 bit wide: when 1, the register loads or advances; when 0, it holds.
REQ-006 Port i_Seed_DV SHALL be an input, 1 bit wide: when 1 together with i_Enable, the seed is loaded.
REQ-007 Port i_Seed_Data SHALL be an input, NUM_BITS wide, and is both the seed value and the done-compare value.
REQ-008 Port o_LFSR_Data SHALL be an output, NUM_BITS wide, and is the current register contents.
REQ-009 Port o_LFSR_Done SHALL be an output, 1 bit wide: 1 when o_LFSR_Data equals i_Seed_Data.
REQ-010 The block SHALL be usable as the plaintext and key stimulus source for aes_128, with 128-bit state and key.

Function
REQ-011 On each rising edge, priority SHALL be: i_Rst, then i_Enable&i_Seed_DV (load i_Seed_Data), then i_Enable (advance), else hold.
REQ-012 i_Seed_DV=1 with i_Enable=0 SHALL be ignored, and the register holds.
REQ-013 When advancing, the next state SHALL be {d[NUM_BITS-2:0], fb}, i.e. a left shift with the new bit entering at the LSB.
REQ-014 fb SHALL be the XNOR of the tap bits; tap k (1-indexed) means bit d[k-1].
REQ-015 Taps for widths 3 to 9 SHALL be: 3:3,2; 4:4,3; 5:5,3; 6:6,5; 7:7,6; 8:8,6,5,4; 9:9,5.
REQ-016 Taps for widths 10 to 16 SHALL be: 10:10,7; 11:11,9; 12:12,6,4,1; 13:13,4,3,1; 14:14,5,3,1; 15:15,14; 16:16,15,13,4.
REQ-017 Taps for widths 17 to 23 SHALL be: 17:17,14; 18:18,11; 19:19,6,2,1; 20:20,17; 21:21,19; 22:22,21; 23:23,18.
REQ-018 Taps for widths 24 to 32 SHALL be: 24:24,23,22,17; 25:25,22; 26:26,6,2,1; 27:27,5,2,1; 28:28,25; 29:29,27; 30:30,6,4,1; 31:31,28; 32:32,22,2,1.
REQ-019 Taps for widths 64 and 128 SHALL be: 64:64,63,61,60; 128:128,126,101,99.
REQ-020 Any NUM_BITS not listed SHALL cause an elaboration error.
REQ-021 Sequences SHALL be maximal length with period 2^NUM_BITS-1; all-zeros is a legal state.
REQ-022 The all-ones state SHALL be the lockup state: advancing from it yields all-ones, and the block takes no corrective action.
REQ-023 o_LFSR_Done SHALL be purely combinational (register == i_Seed_Data) and is not registered or latched.
REQ-024 Changing i_Seed_Data mid-run SHALL affect only o_LFSR_Done and the next load, never the current state.
REQ-025 o_LFSR_Data SHALL be driven directly from the register, with zero output latency.

Reset
REQ-026 While i_Rst=1 at a rising edge, the register SHALL clear to all-zeros, regardless of i_Enable and i_Seed_DV.
REQ-027 After reset, o_LFSR_Data SHALL be 0 and o_LFSR_Done = (i_Seed_Data==0).
REQ-028 Reset asserted mid-sequence SHALL take effect at that edge, and advancing resumes from 0 after release.
REQ-029 No initial-value reliance SHALL exist; state is defined only after the first reset or seed load.

Verification
REQ-030 NUM_BITS=3, reset, i_Enable=1, i_Seed_DV=0, 7 edges -> o_LFSR_Data 001,011,110,101,010,100,000 (period 7).
REQ-031 NUM_BITS=3, seed 111 loaded, then advance -> output stays 111 (lockup).
REQ-032 NUM_BITS=128, load 0xDEADBEEF x4, then advance one edge -> 0xBD5B7DDF_BD5B7DDF_BD5B7DDF_BD5B7DDF.
REQ-033 NUM_BITS=128, seed 0xCAFEFEED x4 loaded -> o_LFSR_Done=1 immediately after load, 0 after one advance.
REQ-034 i_Enable=0 with i_Seed_DV=1 for 5 edges -> output unchanged; i_Rst=1 with i_Enable=i_Seed_DV=1 -> output 0.
REQ-035 NUM_BITS=4, reset then 15 advances -> 15 distinct states, returns to 0, and o_LFSR_Done pulses when seed=0.
